dp_result_collector: RTL and testbench
======================================

// Module: dp_result_collector
// PURPOSE
//   Receive-side companion for our fixed-latency, non-stallable datapath circuits (circuit4 style:
//   free-running SREG stages, no handshake). Issues per-vector credit to the input source,
//   tracks in-flight vectors with a valid pipeline matched to datapath latency, captures x/z
//   when they emerge, and buffers them in a FIFO drained over a valid/ready handshake.
//   Sits between the datapath outputs and any consumer that may apply backpressure.
// PARAMETERS
//   DATAWIDTH  32  width of each captured result (x, z), signed
//   LATENCY    2   clock edges from input acceptance to valid dp_x/dp_z (circuit4 = 2); >= 1
//   DEPTH      4   result FIFO entries; >= LATENCY; need not be a power of 2
// PORTS
//   Clk        in   1            rising-edge clock shared with the datapath
//   Rst        in   1            asynchronous, active-low reset
//   in_valid   in   1            source presents a,b,c to the datapath this cycle
//   in_ready   out  1            collector has credit; vector accepted when in_valid & in_ready
//   dp_x       in   DATAWIDTH    datapath x output (signed)
//   dp_z       in   DATAWIDTH    datapath z output (signed)
//   out_valid  out  1            FIFO head holds a result
//   out_ready  in   1            consumer takes head when out_valid & out_ready
//   out_x      out  DATAWIDTH    head result x
//   out_z      out  DATAWIDTH    head result z
//   count      out  clog2(DEPTH+1) FIFO occupancy
//   ovf_err    out  1            sticky: write attempted while FIFO full (must never fire)
// BEHAVIOUR
//   Reset (Rst=0, async): vld pipeline cleared, FIFO empty, count=0, out_valid=0,
//     out_x=out_z=0, ovf_err=0, in_ready=1 (DEPTH>=1). In-flight vectors discarded.
//   accept = in_valid & in_ready. vld[0] <= accept; vld[i] <= vld[i-1] each edge, no stall.
//   Capture: when vld[LATENCY-1]=1, FIFO write of {dp_x,dp_z} at the next edge.
//     Vector accepted at edge k -> written at edge k+LATENCY -> out_valid from that cycle.
//   inflight = popcount(vld); credits_used = inflight + count.
//   in_ready = (credits_used < DEPTH), combinational from registered state only;
//     never depends on in_valid. A pop in the same cycle does NOT free credit until next cycle.
//   FIFO: first-word-fall-through; out_x/out_z = head entry, out_valid = (count != 0).
//   pop = out_valid & out_ready. Simultaneous push+pop: count unchanged, both pointers advance.
//   Pointers wrap DEPTH-1 -> 0 (non-power-of-2 DEPTH supported).
//   Push while full: data dropped, ovf_err <= 1 (sticky until reset); unreachable by credit rule.
//   out_x/out_z hold last head value when empty (don't-care to consumer, but stable).
//   Results are passed unmodified (no sign/width change); order strictly preserved.
//   Throughput: one result per cycle sustained when out_ready=1 and DEPTH >= LATENCY+1.
// TESTING
//   1. Single vector a=5,b=3,c=1 (x=2,z=6): in_valid 1 cycle -> out_valid rises exactly
//      LATENCY edges after accept; out_x=2, out_z=6; count 0->1->0 after out_ready.
//   2. a=1,b=2,c=2 (d==e, x=3,z=1) then a=5,b=3,c=1 back-to-back, out_ready=1 -> results
//      (3,1) then (2,6) on consecutive cycles, in order.
//   3. out_ready=0, in_valid held 1: exactly DEPTH vectors accepted, in_ready then 0,
//      count=DEPTH, ovf_err=0; release out_ready -> DEPTH pops, in_ready returns 1 next cycle.
//   4. Steady stream, out_ready toggling 1/0 each cycle: no loss, no duplication, order
//      kept across pointer wrap (>= 3*DEPTH vectors), ovf_err=0.
//   5. Rst pulsed low mid-stream with 2 in flight and 2 stored: immediately out_valid=0,
//      count=0, in_ready=1; no stale result appears after Rst release.
//   6. Push+pop same cycle at count=DEPTH-1 and at count=1: count unchanged, data correct.

Source files
------------

// File: rtl/dp_result_collector.sv
// Result collector for fixed-latency, non-stallable datapaths: credit-gated input acceptance,
// a valid pipeline that tracks in-flight vectors, and a first-word-fall-through result FIFO.
module dp_result_collector #(
    parameter int DATAWIDTH = 32,
    parameter int LATENCY   = 2,
    parameter int DEPTH     = 4,
    localparam int CW  = $clog2(DEPTH + 1),
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int FW  = $clog2(LATENCY + 1),
    localparam int CRW = $clog2(DEPTH + LATENCY + 1)
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATAWIDTH-1:0] dp_x,
    input  logic signed [DATAWIDTH-1:0] dp_z,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATAWIDTH-1:0] out_x,
    output logic signed [DATAWIDTH-1:0] out_z,
    output logic [CW-1:0]               count,
    output logic                        ovf_err
);

    typedef struct packed {
        logic signed [DATAWIDTH-1:0] x;
        logic signed [DATAWIDTH-1:0] z;
    } res_t;

    logic [LATENCY-1:0] vld_pipe;
    logic [FW-1:0]      inflight;
    logic [CRW-1:0]     credits_used;
    logic               accept;
    logic               push;
    logic               pop;
    logic               full;
    logic               wr_en;

    res_t               mem [0:DEPTH-1];
    res_t               din;
    res_t               head;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_nxt;
    logic [PW-1:0]      rd_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic [CW-1:0]      remain;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit covers both stored results and vectors still inside the datapath, so a
    // result can never arrive at a full FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight = inflight + FW'(vld_pipe[i]);
        credits_used = CRW'(inflight) + CRW'(count);
    end

    assign in_ready  = (credits_used < CRW'(DEPTH));
    assign accept    = in_valid & in_ready;
    assign push      = vld_pipe[LATENCY-1];
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & ~full;
    assign din       = '{x: dp_x, z: dp_z};

    always_comb begin
        wr_nxt  = wr_en ? ptr_inc(wr_ptr) : wr_ptr;
        rd_nxt  = pop ? ptr_inc(rd_ptr) : rd_ptr;
        remain  = count - CW'(pop);
        cnt_nxt = remain + CW'(wr_en);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= accept;
            for (int i = 1; i < LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= din;
    end

    // Head is registered so the outputs hold their last value once the FIFO drains.
    // When the entry being written becomes the head, it bypasses the memory.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            head    <= '0;
            ovf_err <= 1'b0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            if (wr_en && remain == '0)
                head <= din;
            else if (cnt_nxt != '0)
                head <= mem[rd_nxt];
            if (push && full)
                ovf_err <= 1'b1;
        end
    end

    assign out_x = head.x;
    assign out_z = head.z;

endmodule

// File: tb/tb_dp_result_collector.sv
// Directed bench for dp_result_collector with a two-stage datapath model feeding dp_x/dp_z.
module tb_dp_result_collector;

    localparam int DW    = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] dp_x, dp_z;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] out_x, out_z;
    logic [CW-1:0]        count;
    logic                 ovf_err;

    logic signed [DW-1:0] src_x = 0, src_z = 0;
    logic signed [DW-1:0] st1_x, st1_z, st2_x, st2_z;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 Clk = ~Clk;

    // Free-running datapath model: results appear two edges after the inputs.
    always @(posedge Clk) begin
        st1_x <= src_x;
        st1_z <= src_z;
        st2_x <= st1_x;
        st2_z <= st1_z;
    end
    assign dp_x = st2_x;
    assign dp_z = st2_z;

    dp_result_collector #(.DATAWIDTH(DW), .LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .dp_x(dp_x), .dp_z(dp_z), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_z(out_z), .count(count), .ovf_err(ovf_err)
    );

    task automatic tick();
        @(negedge Clk);
    endtask

    task automatic test_reset();
        tick(); tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0d want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (count !== 0) $display("FAIL reset_count: got %0d want 0", count); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0d want 1", in_ready); else pass_cnt++;
        chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL reset_ovf: got %0d want 0", ovf_err); else pass_cnt++;
        chk_cnt++; if (out_x !== 0 || out_z !== 0) $display("FAIL reset_out_xz: got %0d,%0d want 0,0", out_x, out_z); else pass_cnt++;
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_valid = 1'b1; src_x = 2; src_z = 6; out_ready = 1'b0;
        tick();
        in_valid = 1'b0; src_x = 99; src_z = 99;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early1: got %0d want 0", out_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_early2: got %0d want 0", out_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b1 || count !== 1) $display("FAIL single_valid: got v=%0d c=%0d want v=1 c=1", out_valid, count); else pass_cnt++;
        chk_cnt++; if (out_x !== 2 || out_z !== 6) $display("FAIL single_data: got %0d,%0d want 2,6", out_x, out_z); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk_cnt++; if (out_valid !== 1'b0 || count !== 0) $display("FAIL single_drain: got v=%0d c=%0d want v=0 c=0", out_valid, count); else pass_cnt++;
        chk_cnt++; if (out_x !== 2 || out_z !== 6) $display("FAIL single_hold: got %0d,%0d want 2,6", out_x, out_z); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1; src_x = 3; src_z = 1;
        tick();
        src_x = 2; src_z = 6;
        tick();
        in_valid = 1'b0; src_x = 77; src_z = 77;
        tick();
        chk_cnt++; if (out_valid !== 1'b1 || out_x !== 3 || out_z !== 1) $display("FAIL b2b_first: got v=%0d %0d,%0d want v=1 3,1", out_valid, out_x, out_z); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b1 || out_x !== 2 || out_z !== 6 || count !== 1) $display("FAIL b2b_second: got v=%0d %0d,%0d c=%0d want v=1 2,6 c=1", out_valid, out_x, out_z, count); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0 || count !== 0) $display("FAIL b2b_empty: got v=%0d c=%0d want v=0 c=0", out_valid, count); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        int acc = 0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            src_x = 10 + acc; src_z = -(10 + acc);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk_cnt++; if (acc !== DEPTH) $display("FAIL fill_accepted: got %0d want %0d", acc, DEPTH); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0 || count !== DEPTH) $display("FAIL fill_full: got r=%0d c=%0d want r=0 c=%0d", in_ready, count, DEPTH); else pass_cnt++;
        chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL fill_ovf: got %0d want 0", ovf_err); else pass_cnt++;
        out_ready = 1'b1;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_credit_same_cycle: got %0d want 0", in_ready); else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_x !== 10 + i || out_z !== -(10 + i)) $display("FAIL fill_pop%0d: got v=%0d %0d,%0d want v=1 %0d,%0d", i, out_valid, out_x, out_z, 10 + i, -(10 + i)); else pass_cnt++;
            tick();
            if (i == 0) begin
                chk_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_credit_back: got %0d want 1", in_ready); else pass_cnt++;
            end
        end
        chk_cnt++; if (count !== 0 || out_valid !== 1'b0) $display("FAIL fill_drained: got c=%0d v=%0d want 0,0", count, out_valid); else pass_cnt++;
        out_ready = 1'b0;
    endtask

    task automatic test_toggle();
        localparam int N = 14;
        int sent = 0, rcvd = 0, cyc = 0;
        while (rcvd < N && cyc < 400) begin
            out_ready = cyc[0];
            if (out_valid && out_ready) begin
                chk_cnt++; if (out_x !== 100 + rcvd || out_z !== -7 * rcvd) $display("FAIL toggle_data%0d: got %0d,%0d want %0d,%0d", rcvd, out_x, out_z, 100 + rcvd, -7 * rcvd); else pass_cnt++;
                rcvd++;
            end
            in_valid = (sent < N);
            src_x = 100 + sent; src_z = -7 * sent;
            if (in_valid && in_ready) sent++;
            cyc++;
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk_cnt++; if (rcvd !== N) $display("FAIL toggle_timeout: got %0d results want %0d", rcvd, N); else pass_cnt++;
        repeat (4) tick();
        chk_cnt++; if (count !== 0 || out_valid !== 1'b0) $display("FAIL toggle_no_dup: got c=%0d v=%0d want 0,0", count, out_valid); else pass_cnt++;
        chk_cnt++; if (ovf_err !== 1'b0) $display("FAIL toggle_ovf: got %0d want 0", ovf_err); else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_x = 40 + i; src_z = 50 + i;
            tick();
        end
        in_valid = 1'b0;
        chk_cnt++; if (count !== 2) $display("FAIL mid_pre_count: got %0d want 2", count); else pass_cnt++;
        Rst = 1'b0;
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || count !== 0 || in_ready !== 1'b1) $display("FAIL mid_reset: got v=%0d c=%0d r=%0d want 0,0,1", out_valid, count, in_ready); else pass_cnt++;
        tick();
        Rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_cnt++; if (out_valid !== 1'b0 || count !== 0) $display("FAIL mid_stale%0d: got v=%0d c=%0d want 0,0", i, out_valid, count); else pass_cnt++;
        end
    endtask

    task automatic test_push_pop();
        // count = DEPTH-1 case
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_x = 200 + i; src_z = 300 + i;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk_cnt++; if (count !== DEPTH - 1) $display("FAIL pp_hi_pre: got %0d want %0d", count, DEPTH - 1); else pass_cnt++;
        out_ready = 1'b1;
        chk_cnt++; if (out_x !== 200 || out_z !== 300) $display("FAIL pp_hi_head: got %0d,%0d want 200,300", out_x, out_z); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        chk_cnt++; if (count !== DEPTH - 1 || out_x !== 201 || out_z !== 301) $display("FAIL pp_hi_post: got c=%0d %0d,%0d want c=3 201,301", count, out_x, out_z); else pass_cnt++;
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk_cnt++; if (out_valid !== 1'b1 || out_x !== 200 + i || out_z !== 300 + i) $display("FAIL pp_hi_drain%0d: got v=%0d %0d,%0d want v=1 %0d,%0d", i, out_valid, out_x, out_z, 200 + i, 300 + i); else pass_cnt++;
            tick();
        end
        out_ready = 1'b0;
        // count = 1 case, newly written entry becomes head directly
        in_valid = 1'b1; src_x = -5; src_z = -6;
        tick();
        src_x = -8; src_z = -9;
        tick();
        in_valid = 1'b0; src_x = 0; src_z = 0;
        tick();
        chk_cnt++; if (count !== 1 || out_x !== -5 || out_z !== -6) $display("FAIL pp_lo_pre: got c=%0d %0d,%0d want c=1 -5,-6", count, out_x, out_z); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        chk_cnt++; if (count !== 1 || out_x !== -8 || out_z !== -9) $display("FAIL pp_lo_post: got c=%0d %0d,%0d want c=1 -8,-9", count, out_x, out_z); else pass_cnt++;
        tick();
        out_ready = 1'b0;
        chk_cnt++; if (count !== 0 || ovf_err !== 1'b0) $display("FAIL pp_lo_end: got c=%0d ovf=%0d want 0,0", count, ovf_err); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_fill();
        test_toggle();
        test_reset_midstream();
        test_push_pop();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
